fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle MIPS core. Holds the program counter and requests instructions from instruction memory over a req/ack handshake. Presents the latched instruction and its opcode to the main control decoder and datapath. Computes the next PC from the branch outcome (Branch, Ne, ALU zero) returned for the current instruction.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 17 +
 rtl/pc_next_logic.sv | 45 ++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// Holds the opcode constants, the fetch FSM state type and the default reset PC.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 6;
  localparam int unsigned IMMW   = 16;
  localparam int unsigned JIDXW  = 26;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel (req/ack handshake).
//   imem_req   : read request, driven by the fetch unit
//   imem_addr  : word-aligned fetch address
//   imem_ack   : read data valid this cycle
//   imem_rdata : instruction word
interface fetch_unit_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the fetch stage.
//   pc_plus4_i  : address of the sequential successor
//   imm_i       : branch immediate (instr[15:0])
//   branch_i/ne_i/zero_i : branch outcome for the current instruction
//   opcode_i/jidx_i      : jump decode inputs (FETCH_JUMP_EN builds only)
//   next_pc_c_o : selected next PC
// Build option: FETCH_JUMP_EN adds the j (absolute jump) path.
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]  pc_plus4_i,
  input  logic [IMMW-1:0]  imm_i,
  input  logic             branch_i,
  input  logic             ne_i,
  input  logic             zero_i,
`ifdef FETCH_JUMP_EN
  input  logic [OPW-1:0]   opcode_i,
  input  logic [JIDXW-1:0] jidx_i,
`endif
  output logic [XLEN-1:0]  next_pc_c_o
);

  logic            taken_c;
  logic [XLEN-1:0] br_off_c;

  // Branch selects on branch first so ne/zero cannot leak X for non-branches.
  always_comb begin
    taken_c     = 1'b0;
    br_off_c    = {{(XLEN-IMMW-2){imm_i[IMMW-1]}}, imm_i, 2'b00};
    next_pc_c_o = pc_plus4_i;
    if (branch_i) begin
      taken_c = ne_i ? ~zero_i : zero_i;
    end
    if (taken_c) begin
      next_pc_c_o = XLEN'(pc_plus4_i + br_off_c);
    end
`ifdef FETCH_JUMP_EN
    // A jump overrides any branch outcome.
    if (opcode_i == OP_J) begin
      next_pc_c_o = {pc_plus4_i[XLEN-1:XLEN-4], jidx_i, 2'b00};
    end
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the latched instruction and advances the PC after execution.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory master port (req/addr/ack/rdata)
//   stall        : holds the current instruction in S_EXEC
//   branch/ne/zero : branch outcome, sampled on the edge leaving S_EXEC
//   instr/opcode : latched instruction and its opcode
//   instr_valid  : high exactly while in S_EXEC
//   pc/pc_plus4  : current instruction address and its successor
// Build option: FETCH_JUMP_EN enables the j instruction path.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              branch,
  input  logic              ne,
  input  logic              zero,
  output logic [XLEN-1:0]   instr,
  output logic [OPW-1:0]    opcode,
  output logic              instr_valid,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, valid_q;
  logic [XLEN-1:0] next_pc_c;

  pc_next_logic u_pc_next (
    .pc_plus4_i  (pc_plus4_q),
    .imm_i       (instr_q[IMMW-1:0]),
    .branch_i    (branch),
    .ne_i        (ne),
    .zero_i      (zero),
`ifdef FETCH_JUMP_EN
    .opcode_i    (instr_q[XLEN-1:XLEN-OPW]),
    .jidx_i      (instr_q[JIDXW-1:0]),
`endif
    .next_pc_c_o (next_pc_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc_c;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pc_plus4_d = XLEN'(pc_d + 32'd4);
  end

  // State and output registers; req/valid are registered state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= XLEN'(RESET_PC + 32'd4);
      instr_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      req_q      <= (state_d == S_FETCH);
      valid_q    <= (state_d == S_EXEC);
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[XLEN-1:XLEN-OPW];
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instructions with branch
// outcomes and expected next fetch address, plus reset-mid-fetch and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, ne, zero;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        instr_valid;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus.master),
    .stall       (stall),
    .branch      (branch),
    .ne          (ne),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int unsigned waits;
    int unsigned stalls;
    logic        br;
    logic        ne;
    logic        zero;
    logic [31:0] exp_next;
  } vec_t;

`ifdef FETCH_JUMP_EN
  localparam logic [31:0] J_EXP = 32'h0000_0040;
`else
  localparam logic [31:0] J_EXP = 32'h0000_0104;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_pc;
  logic [31:0] exp_q[$];
  vec_t        vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (pc model %08h)", nm, act, exp, model_pc);
    end
  endtask

  // One full instruction: fetch with waits, execute with stalls, resolve branch.
  task automatic run_instr(input vec_t v);
    int n;
    logic [31:0] e;
    n = 0;
    while (!imem_bus.imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_bus.imem_req), 32'd1);
    check("fetch_addr", imem_bus.imem_addr, model_pc);
    for (int w = 0; w < int'(v.waits); w++) begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req", 32'(imem_bus.imem_req), 32'd1);
      check("wait_addr", imem_bus.imem_addr, model_pc);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = v.word;
    exp_q.push_back(v.word);
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req", 32'(imem_bus.imem_req), 32'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("instr", instr, e);
      check("opcode", 32'(opcode), 32'(e[31:26]));
    end
    check("pc", pc, model_pc);
    check("pc_plus4", pc_plus4, 32'(model_pc + 32'd4));
    // Stray acks during execute must be ignored.
    for (int s = 0; s < int'(v.stalls); s++) begin
      stall               = 1'b1;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, v.word);
      check("stall_pc", pc, model_pc);
      check("stall_req", 32'(imem_bus.imem_req), 32'd0);
    end
    stall             = 1'b0;
    imem_bus.imem_ack = 1'b0;
    branch = v.br;
    ne     = v.ne;
    zero   = v.zero;
    @(negedge clk);
    branch = 1'b0;
    ne     = 1'b0;
    zero   = 1'b0;
    check("post_valid", 32'(instr_valid), 32'd0);
    check("post_req", 32'(imem_bus.imem_req), 32'd1);
    check("next_addr", imem_bus.imem_addr, v.exp_next);
    model_pc = v.exp_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
    vecs[3]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    vecs[4]  = '{32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0020};
    vecs[5]  = '{32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0024};
    vecs[6]  = '{32'h1000_0006, 1, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0040};
    vecs[7]  = '{32'h1400_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_003C};
    vecs[8]  = '{32'h0109_5020, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0040};
    vecs[9]  = '{32'h8C00_0000, 0, 0, 1'b0, 1'bx, 1'b1, 32'h0000_0044};
    vecs[10] = '{32'h1400_0005, 0, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0048};
    vecs[11] = '{32'h1000_002D, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0100};
    vecs[12] = '{32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b0, J_EXP};

    rst_n = 1'b0;
    stall = 1'b0; branch = 1'b0; ne = 1'b0; zero = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    model_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_to_fetch", 32'(imem_bus.imem_req), 32'd1);

    for (int i = 0; i < 13; i++) run_instr(vecs[i]);

    // Reset while a fetch is outstanding; a late ack must not load instr.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_bus.imem_req), 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_addr", imem_bus.imem_addr, 32'h0);
    check("midrst_instr", instr, 32'h0);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_req", 32'(imem_bus.imem_req), 32'd1);
    model_pc = 32'h0;

    // Backward branch to the top of the address space, then wrap to zero.
    run_instr('{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC});
    run_instr('{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000});

    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
